// File: rtl/soc_bus_pkg.sv
// Shared types and address-decode helper for the single-master bus fabric.
package soc_bus_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    // Tracker index width is fixed so the entry type can live here; fabrics up to 16 slaves.
    localparam int MAX_SLAVES = 16;
    localparam int IDX_W      = $clog2(MAX_SLAVES);

    typedef struct packed {
        logic             unmapped;
        logic [IDX_W-1:0] index;
    } tracker_entry_t;

    typedef enum logic [1:0] {
        RESP_OK,
        RESP_UNMAPPED,
        RESP_TIMEOUT
    } resp_kind_t;

    // Offset form avoids overflow when base+size wraps past 2^32.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] address,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] size);
        logic [ADDR_W-1:0] offset;
        offset = address - base;
        return (address >= base) && (offset < size);
    endfunction

endpackage

// File: rtl/soc_read_tracker.sv
// In-order FIFO of outstanding reads; head is the oldest entry awaiting a response.
module soc_read_tracker
    import soc_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  tracker_entry_t         pushEntry,
    input  logic                   pop,
    output tracker_entry_t         head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    tracker_entry_t   mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign head   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master to N-slave fabric: address decode, in-order read tracking,
// decode-error / timeout responses and quarantine of slaves that time out.
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int                          NUM_SLAVES      = 9,
    parameter int                          MAX_OUTSTANDING = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE     = {NUM_SLAVES{32'h4}},
    parameter int                          TIMEOUT_CYCLES  = 1023,
    parameter logic [DATA_W-1:0]           DEFAULT_DATA    = 32'h0,
    parameter logic [DATA_W-1:0]           TIMEOUT_DATA    = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         read,
    input  logic                         write,
    output logic                         waitRequest,
    output logic                         readValid,
    output logic [DATA_W-1:0]            dataIn,
    output logic                         readError,
    output logic                         strayResponse,
    output logic [NUM_SLAVES-1:0]        quarantined,
    output logic [NUM_SLAVES-1:0]        slaveRead,
    output logic [NUM_SLAVES-1:0]        slaveWrite,
    output logic [ADDR_W-1:0]            slaveAddress,
    input  logic [NUM_SLAVES*DATA_W-1:0] slaveData,
    input  logic [NUM_SLAVES-1:0]        slaveValid,
    input  logic [NUM_SLAVES-1:0]        slaveWaitRequest
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              hitValid;
    logic [IDX_W-1:0]  hitIdx;
    logic [ADDR_W-1:0] hitBase;
    logic              hitWait;

    tracker_entry_t    pushEntry;
    tracker_entry_t    head;
    logic [CNT_W-1:0]  trkCount;
    logic              trkFull;
    logic              trkEmpty;
    logic              readAccept;

    logic [NUM_SLAVES-1:0] headSel;
    logic [NUM_SLAVES-1:0] srcMask;
    logic                  headValid;
    logic [DATA_W-1:0]     headData;
    logic                  pop;
    resp_kind_t            respKind;
    logic [DATA_W-1:0]     respData;
    logic                  strayNow;
    logic [TMO_W-1:0]      tmoCount;

    logic                  vld_p1;
    logic                  err_p1;
    logic                  stray_p1;
    logic [DATA_W-1:0]     data_p1;

    // Downward scan so the lowest matching index is the last one written.
    always_comb begin
        hitValid = 1'b0;
        hitIdx   = '0;
        hitBase  = '0;
        hitWait  = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (!quarantined[i] &&
                addr_hit(address, SLAVE_BASE[i*ADDR_W +: ADDR_W], SLAVE_SIZE[i*ADDR_W +: ADDR_W])) begin
                hitValid = 1'b1;
                hitIdx   = IDX_W'(i);
                hitBase  = SLAVE_BASE[i*ADDR_W +: ADDR_W];
                hitWait  = slaveWaitRequest[i];
            end
        end
    end

    always_comb begin
        slaveRead  = '0;
        slaveWrite = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hitValid && hitIdx == IDX_W'(i)) begin
                slaveRead[i]  = read & ~trkFull;
                slaveWrite[i] = write;
            end
        end
    end

    assign slaveAddress = address - hitBase;
    assign waitRequest  = (hitValid & hitWait) | (read & trkFull);
    assign readAccept   = read & ~waitRequest;
    assign pushEntry    = '{unmapped: ~hitValid, index: hitIdx};

    soc_read_tracker #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .push      (readAccept),
        .pushEntry (pushEntry),
        .pop       (pop),
        .head      (head),
        .count     (trkCount),
        .full      (trkFull),
        .empty     (trkEmpty)
    );

    // A quarantined slave can no longer complete its own entries; they time out.
    always_comb begin
        headSel   = '0;
        headValid = 1'b0;
        headData  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (head.index == IDX_W'(i)) begin
                headSel[i] = 1'b1;
                headValid  = slaveValid[i] & ~quarantined[i];
                headData   = slaveData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        pop      = 1'b0;
        respKind = RESP_OK;
        srcMask  = '0;
        if (!trkEmpty) begin
            if (head.unmapped) begin
                pop      = 1'b1;
                respKind = RESP_UNMAPPED;
            end else if (headValid) begin
                pop      = 1'b1;
                respKind = RESP_OK;
                srcMask  = headSel;
            end else if (tmoCount == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                pop      = 1'b1;
                respKind = RESP_TIMEOUT;
            end
        end
    end

    always_comb begin
        unique case (respKind)
            RESP_UNMAPPED: respData = DEFAULT_DATA;
            RESP_TIMEOUT:  respData = TIMEOUT_DATA;
            default:       respData = headData;
        endcase
    end

    assign strayNow = |(slaveValid & ~srcMask);

    // ---- stage p1: registered response ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
            stray_p1    <= 1'b0;
            data_p1     <= '0;
            tmoCount    <= '0;
            quarantined <= '0;
        end else begin
            vld_p1   <= pop;
            err_p1   <= pop && (respKind != RESP_OK);
            stray_p1 <= strayNow;
            if (pop) data_p1 <= respData;
            if (pop || trkCount == '0)  tmoCount <= '0;
            else if (tmoCount != '1)    tmoCount <= tmoCount + 1'b1;
            if (pop && respKind == RESP_TIMEOUT) quarantined <= quarantined | headSel;
        end
    end

    assign readValid     = vld_p1;
    assign readError     = err_p1;
    assign strayResponse = stray_p1;
    assign dataIn        = data_p1;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: decode table plus multi-cycle read sequences.
module tb_soc_bus_fabric;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  address;
    logic         read;
    logic         write;
    logic         waitRequest;
    logic         readValid;
    logic [31:0]  dataIn;
    logic         readError;
    logic         strayResponse;
    logic [8:0]   quarantined;
    logic [8:0]   slaveRead;
    logic [8:0]   slaveWrite;
    logic [31:0]  slaveAddress;
    logic [287:0] slaveData;
    logic [8:0]   slaveValid;
    logic [8:0]   slaveWaitRequest;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    soc_bus_fabric #(
        .NUM_SLAVES      (9),
        .MAX_OUTSTANDING (4),
        .SLAVE_BASE      ({32'h70800, 32'h70000, 32'h60000, 32'h50000, 32'h40000,
                           32'h30000, 32'h20000, 32'h10000, 32'h0}),
        .SLAVE_SIZE      ({32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000,
                           32'h1000, 32'h1000, 32'h1000, 32'h4000}),
        .TIMEOUT_CYCLES  (8),
        .DEFAULT_DATA    (32'h0),
        .TIMEOUT_DATA    (32'hDEADBEEF)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .address          (address),
        .read             (read),
        .write            (write),
        .waitRequest      (waitRequest),
        .readValid        (readValid),
        .dataIn           (dataIn),
        .readError        (readError),
        .strayResponse    (strayResponse),
        .quarantined      (quarantined),
        .slaveRead        (slaveRead),
        .slaveWrite       (slaveWrite),
        .slaveAddress     (slaveAddress),
        .slaveData        (slaveData),
        .slaveValid       (slaveValid),
        .slaveWaitRequest (slaveWaitRequest)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [8:0]  sw;
        logic [8:0]  eRd;
        logic [8:0]  eWr;
        logic        eWait;
        logic [31:0] eAddr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setData(input int idx, input logic [31:0] d);
        slaveData[idx*32 +: 32] = d;
    endtask

    initial begin
        int lat;

        vecs[0]  = '{32'h00000010, 1'b1, 1'b0, 9'h000, 9'h001, 9'h000, 1'b0, 32'h10};
        vecs[1]  = '{32'h00010004, 1'b0, 1'b1, 9'h000, 9'h000, 9'h002, 1'b0, 32'h4};
        vecs[2]  = '{32'h00003FFC, 1'b1, 1'b0, 9'h000, 9'h001, 9'h000, 1'b0, 32'h3FFC};
        vecs[3]  = '{32'h00004000, 1'b1, 1'b0, 9'h000, 9'h000, 9'h000, 1'b0, 32'h4000};
        vecs[4]  = '{32'h0F000000, 1'b0, 1'b1, 9'h1FF, 9'h000, 9'h000, 1'b0, 32'h0F000000};
        vecs[5]  = '{32'h00070900, 1'b1, 1'b0, 9'h000, 9'h080, 9'h000, 1'b0, 32'h900};
        vecs[6]  = '{32'h00071000, 1'b1, 1'b0, 9'h000, 9'h100, 9'h000, 1'b0, 32'h800};
        vecs[7]  = '{32'h000717FF, 1'b0, 1'b1, 9'h000, 9'h000, 9'h100, 1'b0, 32'hFFF};
        vecs[8]  = '{32'h00071800, 1'b1, 1'b0, 9'h000, 9'h000, 9'h000, 1'b0, 32'h71800};
        vecs[9]  = '{32'h00020010, 1'b1, 1'b0, 9'h004, 9'h004, 9'h000, 1'b1, 32'h10};
        vecs[10] = '{32'h00020010, 1'b1, 1'b0, 9'h008, 9'h004, 9'h000, 1'b0, 32'h10};
        vecs[11] = '{32'h00030000, 1'b1, 1'b1, 9'h000, 9'h008, 9'h008, 1'b0, 32'h0};

        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        slaveData = '0; slaveValid = '0; slaveWaitRequest = '0;
        tick(); tick();
        check("rst readValid", 32'(readValid), 32'h0);
        check("rst dataIn", dataIn, 32'h0);
        check("rst readError", 32'(readError), 32'h0);
        check("rst stray", 32'(strayResponse), 32'h0);
        check("rst quarantined", 32'(quarantined), 32'h0);
        reset = 1'b0;

        // Combinational decode; requests are dropped before the next edge so nothing is tracked.
        for (int i = 0; i < 12; i++) begin
            tick();
            address = vecs[i].addr; read = vecs[i].rd; write = vecs[i].wr;
            slaveWaitRequest = vecs[i].sw;
            #1;
            check($sformatf("dec%0d slaveRead", i), 32'(slaveRead), 32'(vecs[i].eRd));
            check($sformatf("dec%0d slaveWrite", i), 32'(slaveWrite), 32'(vecs[i].eWr));
            check($sformatf("dec%0d waitRequest", i), 32'(waitRequest), 32'(vecs[i].eWait));
            check($sformatf("dec%0d slaveAddress", i), slaveAddress, vecs[i].eAddr);
            read = 1'b0; write = 1'b0; slaveWaitRequest = '0;
        end

        // Mapped read, valid two cycles after acceptance.
        tick();
        address = 32'h10; read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        slaveValid = 9'h001; setData(0, 32'h12345678);
        check("A pre readValid", 32'(readValid), 32'h0);
        tick();
        slaveValid = '0;
        check("A readValid", 32'(readValid), 32'h1);
        check("A dataIn", dataIn, 32'h12345678);
        check("A readError", 32'(readError), 32'h0);
        tick();
        check("A readValid drop", 32'(readValid), 32'h0);

        // Unmapped read and write.
        address = 32'h0F000000; read = 1'b1;
        tick();
        read = 1'b0;
        check("B T+1 readValid", 32'(readValid), 32'h0);
        tick();
        check("B readValid", 32'(readValid), 32'h1);
        check("B dataIn", dataIn, 32'h0);
        check("B readError", 32'(readError), 32'h1);
        write = 1'b1;
        #1;
        check("B wr waitRequest", 32'(waitRequest), 32'h0);
        check("B wr strobes", 32'(slaveWrite), 32'h0);
        write = 1'b0;
        tick();

        // Fill the tracker with reads to slave 3.
        for (int k = 0; k < 4; k++) begin
            address = 32'h30000 + 32'(4 * k); read = 1'b1;
            #1;
            check($sformatf("C push%0d waitRequest", k), 32'(waitRequest), 32'h0);
            tick();
        end
        check("C full waitRequest", 32'(waitRequest), 32'h1);
        check("C full slaveRead", 32'(slaveRead), 32'h0);
        slaveValid = 9'h008; setData(3, 32'hA0);
        #1;
        check("C pop-same-cycle waitRequest", 32'(waitRequest), 32'h1);
        tick();
        read = 1'b0;
        check("C resp0 readValid", 32'(readValid), 32'h1);
        check("C resp0 dataIn", dataIn, 32'hA0);
        for (int k = 1; k < 4; k++) begin
            setData(3, 32'hA0 + 32'(k));
            tick();
            check($sformatf("C resp%0d readValid", k), 32'(readValid), 32'h1);
            check($sformatf("C resp%0d dataIn", k), dataIn, 32'hA0 + 32'(k));
        end
        slaveValid = '0;
        address = 32'h30010; read = 1'b1;
        #1;
        check("C fifth waitRequest", 32'(waitRequest), 32'h0);
        tick();
        read = 1'b0;
        slaveValid = 9'h008; setData(3, 32'hA5);
        tick();
        slaveValid = '0;
        check("C fifth readValid", 32'(readValid), 32'h1);
        check("C fifth dataIn", dataIn, 32'hA5);

        // Out-of-order valid is stray; in-order responses still delivered.
        address = 32'h10000; read = 1'b1;
        tick();
        address = 32'h20000;
        tick();
        read = 1'b0;
        slaveValid = 9'h004; setData(2, 32'hBAD0BAD0);
        tick();
        check("D stray", 32'(strayResponse), 32'h1);
        check("D stray readValid", 32'(readValid), 32'h0);
        slaveValid = 9'h002; setData(1, 32'h11111111);
        tick();
        check("D s1 readValid", 32'(readValid), 32'h1);
        check("D s1 dataIn", dataIn, 32'h11111111);
        check("D s1 stray", 32'(strayResponse), 32'h0);
        slaveValid = 9'h004; setData(2, 32'h22222222);
        tick();
        slaveValid = '0;
        check("D s2 readValid", 32'(readValid), 32'h1);
        check("D s2 dataIn", dataIn, 32'h22222222);

        // Timeout of slave 4 and subsequent quarantine.
        address = 32'h40000; read = 1'b1;
        tick();
        read = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            tick();
            if (readValid) lat = n;
        end
        check("E timeout latency", 32'(lat), 32'd8);
        check("E dataIn", dataIn, 32'hDEADBEEF);
        check("E readError", 32'(readError), 32'h1);
        check("E quarantined", 32'(quarantined), 32'h010);
        address = 32'h40000; read = 1'b1;
        #1;
        check("E quarantined slaveRead", 32'(slaveRead), 32'h0);
        tick();
        read = 1'b0;
        tick();
        check("E quar readValid", 32'(readValid), 32'h1);
        check("E quar readError", 32'(readError), 32'h1);
        check("E quar dataIn", dataIn, 32'h0);

        // Reset with reads outstanding; late valid becomes stray.
        address = 32'h50000; read = 1'b1;
        tick();
        address = 32'h50004;
        tick();
        address = 32'h60000;
        tick();
        read = 1'b0;
        slaveValid = 9'h020; setData(5, 32'hCAFE0001);
        tick();
        slaveValid = '0;
        check("F pre readValid", 32'(readValid), 32'h1);
        check("F pre dataIn", dataIn, 32'hCAFE0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("F rst readValid", 32'(readValid), 32'h0);
        check("F rst dataIn", dataIn, 32'h0);
        check("F rst readError", 32'(readError), 32'h0);
        check("F rst stray", 32'(strayResponse), 32'h0);
        check("F rst quarantined", 32'(quarantined), 32'h0);
        slaveValid = 9'h020;
        tick();
        slaveValid = '0;
        check("F late stray", 32'(strayResponse), 32'h1);
        check("F late readValid", 32'(readValid), 32'h0);
        tick();
        check("F stray drop", 32'(strayResponse), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/soc_bus_fabric.md
Name: soc_bus_fabric

Overview:
- Parametrised single-master to N-slave memory-mapped bus fabric; the next-generation replacement for the fixed-map SoC interconnect.
- Decodes the CPU address against per-slave base/size tables and steers read/write strobes.
- Tracks up to MAX_OUTSTANDING reads in order and routes each response by the tracked slave index rather than by one-hot valid.
- Adds decode-error and timeout responses, plus quarantine of slaves that time out.

Parameters:
- NUM_SLAVES, 9: number of slave ports.
- MAX_OUTSTANDING, 4: read tracker depth; power of two, at least 2.
- SLAVE_BASE, {NUM_SLAVES{32'h0}}: per-slave base byte address.
- SLAVE_SIZE, {NUM_SLAVES{32'h4}}: per-slave window size in bytes; nonzero.
- TIMEOUT_CYCLES, 1023: cycles the head read may wait before it is force-completed; at least 2.
- DEFAULT_DATA, 32'h0: read data returned for unmapped reads.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned for timed-out reads.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  32  master byte address.
- read  in  1  master read request.
- write  in  1  master write request.
- waitRequest  out  1  master must hold its request this cycle.
- readValid  out  1  read response strobe, registered.
- dataIn  out  32  read response data, registered.
- readError  out  1  qualifies readValid: response is unmapped or timed out.
- strayResponse  out  1  one-cycle pulse: a slave valid arrived that was not expected.
- quarantined  out  NUM_SLAVES  sticky per-slave timeout flags.
- slaveRead  out  NUM_SLAVES  per-slave read strobe.
- slaveWrite  out  NUM_SLAVES  per-slave write strobe.
- slaveAddress  out  32  address minus the selected slave's base; slaves slice the bits they need.
- slaveData  in  NUM_SLAVES*32  per-slave read data.
- slaveValid  in  NUM_SLAVES  per-slave read-data valid.
- slaveWaitRequest  in  NUM_SLAVES  per-slave stall.

Behaviour:
- Decode (combinational): a slave hits when base <= address <= base+size-1. On overlap, the lowest index wins.
- Quarantined slaves never hit; their range decodes as unmapped.
- slaveRead/slaveWrite of the hit slave equal read/write gated by tracker-not-full for reads. All other slaves see 0.
- Strobes are asserted even while waitRequest=1.
- waitRequest = hit slave's slaveWaitRequest, OR (read AND tracker count == MAX_OUTSTANDING).
  - A same-cycle pop does not relieve the full condition.
  - An unmapped write never waits and is discarded.
- Read acceptance: read & ~waitRequest pushes {unmapped, index} into the tracker.
- Write acceptance: write & ~waitRequest; writes are not tracked.
- read and write both high: both are forwarded, and only the read is tracked.
- Head completion, evaluated only while the tracker is non-empty; priority order:
  1. Unmapped entry: completes the first cycle it is head.
  2. slaveValid[head.index]: completes with that slave's data.
  3. Timeout counter == TIMEOUT_CYCLES-1: completes with error.
- On completion: pop the entry. Next cycle: readValid=1, dataIn = DEFAULT_DATA / slaveData / TIMEOUT_DATA respectively, readError = 1 / 0 / 1.
- Latency:
  - Mapped read: slave valid + 1 cycle.
  - Unmapped read on an empty tracker: acceptance at T gives readValid at T+2.
- Timeout counter:
  - Clears on every pop and while the tracker is empty.
  - Otherwise increments by 1 per cycle, saturating.
  - On timeout, sets quarantined[head.index]; the flag is cleared only by reset.
- Stray response: any slaveValid[i] that is not the head-completing source pulses strayResponse the next cycle and is discarded. This covers non-head valids, valids from quarantined slaves, and valids with an empty tracker.
- Back-to-back: one push and one pop may occur in the same cycle; count is unchanged.
- Reset (synchronous, including mid-operation):
  - Tracker emptied; count 0; timeout counter 0; quarantined all 0.
  - readValid, readError and strayResponse 0; dataIn 32'h0.
  - Responses that were in flight before reset are reported as stray.
- Tracker pointers wrap modulo MAX_OUTSTANDING; count is $clog2(MAX_OUTSTANDING)+1 bits.

Decomposition:
- Package soc_bus_pkg:
  - ADDR_W = 32, DATA_W = 32.
  - Typedef tracker_entry_t {unmapped, index[$clog2(NUM_SLAVES)-1:0]}.
  - Response-kind enum {RESP_OK, RESP_UNMAPPED, RESP_TIMEOUT}.
  - Decode function addr_hit(address, base, size).
- Sub-module soc_read_tracker: synchronous FIFO of tracker_entry_t with push, pop, head, count, full and empty.

Test Plan:
- Slave 0 mapped at 0x0/0x4000: read 0x10, slaveValid[0] with 0x12345678 two cycles later -> readValid one cycle after that, dataIn=0x12345678, readError=0.
- Read 0x0F000000 (unmapped) on an empty tracker at cycle T -> readValid at T+2, dataIn=0x0, readError=1; unmapped write -> waitRequest=0, no slave strobe.
- Four reads to slave 3, no valids -> fifth read sees waitRequest=1. Four valids returned one per cycle -> four in-order responses; the fifth read is then accepted.
- Two pipelined reads, slave 1 then slave 2; slave 2 valid arrives first -> strayResponse pulse, slave 2 data dropped, slave 1 response still delivered.
- TIMEOUT_CYCLES=8, read slave 4, no valid -> readValid 8 cycles after the read becomes head, dataIn=0xDEADBEEF, readError=1, quarantined[4]=1. Next read to slave 4 -> unmapped response.
- Reset asserted with two reads outstanding -> next cycle all outputs 0 and count 0; a late slaveValid -> strayResponse=1, readValid=0.
